// File: rtl/conversor_bcd_sequencial_if.sv
// Bus between the result register reader and the BCD converter.
// Fields guarded by SIGNED_DISPLAY_EN exist only in the signed-display build.
interface conversor_bcd_sequencial_if #(
  parameter int WIDTH = 8
);
  // Handshake: the master raises start with data_in valid. It is accepted on
  // the first rising edge where the converter is idle (busy low). busy stays
  // high until done, a one-cycle pulse that also marks the digits as valid.
  // A start seen while busy is dropped, not queued.
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [3:0]       bcd_centenas;
  logic [3:0]       bcd_dezenas;
  logic [3:0]       bcd_unidades;
`ifdef SIGNED_DISPLAY_EN
  logic             negativo;
`endif
  logic             dbg_convert;

  modport master (
    output start, data_in,
    input  busy, done, bcd_centenas, bcd_dezenas, bcd_unidades,
`ifdef SIGNED_DISPLAY_EN
    input  negativo,
`endif
    input  dbg_convert
  );

  modport slave (
    input  start, data_in,
    output busy, done, bcd_centenas, bcd_dezenas, bcd_unidades,
`ifdef SIGNED_DISPLAY_EN
    output negativo,
`endif
    output dbg_convert
  );
endinterface

// File: rtl/conversor_bcd_sequencial.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Define SIGNED_DISPLAY_EN to treat data_in as two's complement and drive negativo.
module conversor_bcd_sequencial #(
  parameter int WIDTH = 8
) (
  input logic                         clk,
  input logic                         reset,
  conversor_bcd_sequencial_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [11:0]      scratch_q, scratch_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       cen_q, cen_d;
  logic [3:0]       dez_q, dez_d;
  logic [3:0]       uni_q, uni_d;
  logic             sign_q, sign_d;
  logic             neg_q, neg_d;

  logic [11:0]       adjusted;
  logic [WIDTH+11:0] shifted;
  logic [WIDTH-1:0]  magnitude;
  logic              sign_in;

  function automatic logic [11:0] add3(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
`ifdef SIGNED_DISPLAY_EN
    sign_in   = bus.data_in[WIDTH-1];
    // The most negative value negates to itself, which is its correct magnitude.
    magnitude = sign_in ? WIDTH'(-bus.data_in) : bus.data_in;
`else
    sign_in   = 1'b0;
    magnitude = bus.data_in;
`endif
    adjusted = add3(scratch_q);
    shifted  = {adjusted, shift_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cen_d     = cen_q;
    dez_d     = dez_q;
    uni_d     = uni_q;
    sign_d    = sign_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = magnitude;
          scratch_d = '0;
          cnt_d     = '0;
          sign_d    = sign_in;
          busy_d    = 1'b1;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = shifted[WIDTH+11:WIDTH];
        shift_d   = shifted[WIDTH-1:0];
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'(WIDTH - 1)) begin
          cen_d   = shifted[WIDTH+11:WIDTH+8];
          dez_d   = shifted[WIDTH+7:WIDTH+4];
          uni_d   = shifted[WIDTH+3:WIDTH];
          neg_d   = sign_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cen_q     <= '0;
      dez_q     <= '0;
      uni_q     <= '0;
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cen_q     <= cen_d;
      dez_q     <= dez_d;
      uni_q     <= uni_d;
      sign_q    <= sign_d;
      neg_q     <= neg_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.bcd_centenas = cen_q;
  assign bus.bcd_dezenas  = dez_q;
  assign bus.bcd_unidades = uni_q;
  assign bus.dbg_convert  = (state_q == CONVERT);
`ifdef SIGNED_DISPLAY_EN
  assign bus.negativo     = neg_q;
`else
  logic unused_sign;
  assign unused_sign = sign_q ^ neg_q;
`endif

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Directed bench for conversor_bcd_sequencial: a cycle-level arithmetic model
// checked every cycle, plus hand-computed digit and latency expectations.
module tb_conversor_bcd_sequencial;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  conversor_bcd_sequencial_if #(.WIDTH(W)) bus ();

  conversor_bcd_sequencial #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (act=running req=finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks only "cycles left in the current conversion"; digits come from
  // plain division of the captured value.
  int m_left = 0;
  int m_val  = 0;
  bit m_sign = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_cen = 0, m_dez = 0, m_uni = 0;
  bit m_neg = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0;
      m_cen = 0; m_dez = 0; m_uni = 0; m_neg = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_cen  = m_val / 100;
          m_dez  = (m_val / 10) % 10;
          m_uni  = m_val % 10;
          m_neg  = m_sign;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (bus.start) begin
        m_val  = int'(bus.data_in);
        m_sign = 1'b0;
`ifdef SIGNED_DISPLAY_EN
        if (bus.data_in[W-1]) begin
          m_val  = (1 << W) - m_val;
          m_sign = 1'b1;
        end
`endif
        m_left = W;
        m_busy = 1'b1;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [11:0] exp_q[$];
  logic [11:0] got_digits;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      chk("centenas", int'(bus.bcd_centenas), m_cen);
      chk("dezenas", int'(bus.bcd_dezenas), m_dez);
      chk("unidades", int'(bus.bcd_unidades), m_uni);
`ifdef SIGNED_DISPLAY_EN
      chk("negativo", int'(bus.negativo), int'(m_neg));
`endif
      if (bus.done) begin
        got_digits = {bus.bcd_centenas, bus.bcd_dezenas, bus.bcd_unidades};
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("queued_result", int'(got_digits), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [W-1:0] v);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = v;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Called at the negedge following the accepting edge (k = 0).
  task automatic wait_done(input string name, input int k0, output int k);
    k = k0;
    while (!bus.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) chk({name, "_timeout"}, k, W);
  endtask

  task automatic expect_digits(input string name, input int c, input int d, input int u);
    chk({name, "_c"}, int'(bus.bcd_centenas), c);
    chk({name, "_d"}, int'(bus.bcd_dezenas), d);
    chk({name, "_u"}, int'(bus.bcd_unidades), u);
  endtask

  task automatic run_one(input string name, input logic [W-1:0] v,
                         input int c, input int d, input int u);
    int k;
    exp_q.push_back({4'(c), 4'(d), 4'(u)});
    do_start(v);
    wait_done(name, 0, k);
    chk({name, "_latency"}, k, W);
    expect_digits(name, c, d, u);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    expect_digits("reset", 0, 0, 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    reset = 1'b0;

    // 1: zero still takes the full latency; done is a single-cycle pulse
    run_one("zero", 8'h00, 0, 0, 0);
    @(negedge clk);
    chk("zero_done_low", int'(bus.done), 0);

    // 2 / 6: extremes and digit-carry boundaries
`ifdef SIGNED_DISPLAY_EN
    run_one("s80", 8'h80, 1, 2, 8);
    chk("s80_neg", int'(bus.negativo), 1);
    run_one("sff", 8'hFF, 0, 0, 1);
    chk("sff_neg", int'(bus.negativo), 1);
    run_one("s7f", 8'h7F, 1, 2, 7);
    chk("s7f_neg", int'(bus.negativo), 0);
`else
    run_one("ff", 8'hFF, 2, 5, 5);
`endif
    run_one("x63", 8'h63, 0, 9, 9);
    run_one("x64", 8'h64, 1, 0, 0);

    // 3: second start while busy is ignored; data_in change has no effect
    exp_q.push_back({4'd0, 4'd4, 4'd2});
    do_start(8'h2A);
    @(negedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'h11;
    @(negedge clk);
    bus.start   = 1'b0;
    wait_done("busy_ignore", 3, k);
    chk("busy_ignore_latency", k, W);
    expect_digits("busy_ignore", 0, 4, 2);
    repeat (12) @(negedge clk);

    // 4: start held high restarts right after each done
    exp_q.push_back({4'd0, 4'd1, 4'd0});
    exp_q.push_back({4'd0, 4'd1, 4'd1});
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'h0A;
    @(negedge clk);
    wait_done("held1", 0, k);
    chk("held1_latency", k, W);
    expect_digits("held1", 0, 1, 0);
    bus.data_in = 8'h0B;
    @(negedge clk);
    wait_done("held2", 0, k);
    bus.start = 1'b0;
    chk("held2_latency", k, W);
    expect_digits("held2", 0, 1, 1);
    @(negedge clk);

    // 5: reset mid-conversion aborts and discards the pending result
    do_start(8'hC8);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_digits("abort", 0, 0, 0);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done_pending", exp_q.size(), 0);
    run_one("after_abort", 8'h07, 0, 0, 7);

    // results persist while idle
    repeat (5) @(negedge clk);
    expect_digits("hold", 0, 0, 7);
    chk("final_queue_empty", exp_q.size(), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
